// File: rtl/logc_pkg.sv
// Shared definitions for the log2 compressor: parameter defaults, output
// width derivation and the Q4.4 sample type.
package logc_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_FRAC_BITS  = 4;

  typedef struct packed {
    logic [3:0] int_part;
    logic [3:0] frac_part;
  } q44_t;

  function automatic int unsigned out_width(input int unsigned data_width,
                                            input int unsigned frac_bits);
    return $clog2(data_width) + frac_bits;
  endfunction

endpackage

// File: rtl/lod.sv
// Combinational leading-one detector: index of the most significant set bit
// of data, plus a flag for an all-zero word.
module lod #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [IDX_W-1:0] index,
  output logic             zero
);

  always_comb begin
    index = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data[i]) index = IDX_W'(i);
    end
    zero = (data == '0);
  end

endmodule

// File: rtl/log_compress.sv
// Three-stage log2 compressor with valid/ready handshake and per-line count.
// Define LOGC_CLAMP_EN to subtract the FLOOR dynamic-range floor (saturating at 0).
module log_compress
  import logc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
  parameter q44_t        FLOOR      = 8'h30,
  localparam int unsigned OUT_WIDTH = out_width(DATA_WIDTH, FRAC_BITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic [15:0]           sample_cnt
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [OUT_WIDTH-1:0] FLOOR_W = OUT_WIDTH'(FLOOR);
`ifdef LOGC_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  logic adv;
  logic xfer;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign xfer     = out_valid && out_ready;

  logic                  s1_valid, s1_last;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_last  <= in_valid && in_last;
      s1_data  <= in_valid ? in_data : '0;
    end
  end

  logic [IDX_W-1:0]      lod_index;
  logic                  lod_zero;
  logic [DATA_WIDTH-1:0] norm;
  logic [FRAC_BITS-1:0]  frac;

  lod #(.WIDTH(DATA_WIDTH)) u_lod (
    .data  (s1_data),
    .index (lod_index),
    .zero  (lod_zero)
  );

  // Shift the leading one to the MSB; the bits below it are the fraction,
  // zero-padded from the right when the sample is short.
  assign norm = s1_data << (MSB_IDX - lod_index);
  assign frac = norm[DATA_WIDTH-2 -: FRAC_BITS];

  logic                 s2_valid, s2_last;
  logic [OUT_WIDTH-1:0] s2_log;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_log   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_log   <= lod_zero ? '0 : {lod_index, frac};
    end
  end

  logic [OUT_WIDTH-1:0] s3_next;

  always_comb begin
    s3_next = s2_log;
    if (CLAMP_EN) s3_next = (s2_log > FLOOR_W) ? s2_log - FLOOR_W : '0;
  end

  logic clr_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      sample_cnt  <= '0;
      clr_pending <= 1'b0;
    end else begin
      if (adv) begin
        out_valid <= s2_valid;
        out_last  <= s2_last;
        out_data  <= s3_next;
      end
      // The count of a finished line stays visible for one cycle, then restarts.
      clr_pending <= xfer && out_last;
      if (clr_pending)
        sample_cnt <= xfer ? 16'd1 : 16'd0;
      else if (xfer)
        sample_cnt <= sample_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_log_compress.sv
// Directed self-checking bench for log_compress: timing, stalls, line count, reset.
module tb_log_compress;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic [15:0] sample_cnt;

  logic [7:0]  exp_raw;
  int          n_vec = 0;
  int          n_err = 0;
  int          rx_cnt = 0;
  logic [8:0]  sb_q[$];
  logic [8:0]  sb_e;

  always #5 clk = ~clk;

  log_compress dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .sample_cnt (sample_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] clampf(input logic [7:0] raw);
`ifdef LOGC_CLAMP_EN
    return (raw > 8'h30) ? raw - 8'h30 : 8'h00;
`else
    return raw;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    exp_raw = '0; out_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  // Scoreboard: expectations come from the hand-computed exp_raw driven with each sample.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          sb_e = sb_q.pop_front();
          chk("sb_data", 32'(out_data), 32'(sb_e[7:0]));
          chk("sb_last", 32'(out_last), 32'(sb_e[8]));
          rx_cnt++;
        end
      end
      if (in_valid && in_ready) sb_q.push_back({in_last, clampf(exp_raw)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  logic [15:0] t1_in  [6] = '{16'h0100, 16'h0180, 16'h0001, 16'h0000, 16'hFFFF, 16'h0004};
  logic [7:0]  t1_raw [6] = '{8'h80, 8'h88, 8'h00, 8'h00, 8'hFF, 8'h20};
  logic [15:0] t2_in  [16] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0008,
                               16'h000F, 16'h0010, 16'h0011, 16'h0020, 16'h00FF, 16'h0100,
                               16'h0A00, 16'h1234, 16'h8000, 16'h7FFF};
  logic [7:0]  t2_raw [16] = '{8'h00, 8'h10, 8'h18, 8'h20, 8'h24, 8'h30,
                               8'h3E, 8'h40, 8'h41, 8'h50, 8'h7F, 8'h80,
                               8'hB4, 8'hC2, 8'hF0, 8'hEF};
  logic [15:0] t3_cnt [9] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0};

  initial begin
    int k, cyc, rx_base;
    logic acc;

    // Reset state
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    exp_raw = '0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back vectors: first result visible after the third edge
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 6);
      in_data  = (i < 6) ? t1_in[i] : 16'h0;
      exp_raw  = (i < 6) ? t1_raw[i] : 8'h0;
      tick();
      if (i < 2) begin
        chk("t1_pre_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'(clampf(t1_raw[i-2])));
      end
    end
    in_valid = 1'b0;
    repeat (3) tick();

    // Streaming with out_ready pattern 1,0,0 repeating
    do_reset();
    rx_base = rx_cnt;
    k = 0;
    cyc = 0;
    while ((k < 16 || sb_q.size() != 0) && cyc < 300) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (k < 16);
      in_data   = (k < 16) ? t2_in[k] : 16'h0;
      exp_raw   = (k < 16) ? t2_raw[k] : 8'h0;
      @(negedge clk);
      chk("t2_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
      cyc++;
    end
    chk("t2_rx_count", 32'(rx_cnt - rx_base), 32'd16);
    in_valid = 1'b0;
    out_ready = 1'b1;

    // One line of five samples
    do_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 5);
      in_last  = (i == 4);
      in_data  = (i < 5) ? t1_in[i] : 16'h0;
      exp_raw  = (i < 5) ? t1_raw[i] : 8'h0;
      tick();
      chk("t3_sample_cnt", 32'(sample_cnt), 32'(t3_cnt[i]));
      if (i >= 2 && i <= 6) chk("t3_out_last", 32'(out_last), 32'(i == 6));
    end
    in_last = 1'b0;

    // Reset mid-stream discards in-flight samples
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = t2_in[i + 4];
      exp_raw  = t2_raw[i + 4];
      if (i == 2) reset = 1'b1;
      tick();
    end
    reset = 1'b0; in_valid = 1'b0;
    chk("t4_cnt_after_rst", 32'(sample_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_flushed", 32'(out_valid), 32'd0);
      tick();
    end
    in_valid = 1'b1; in_data = 16'h0180; exp_raw = 8'h88;
    tick();
    in_valid = 1'b0;
    chk("t4_lat1", 32'(out_valid), 32'd0);
    tick();
    chk("t4_lat2", 32'(out_valid), 32'd0);
    tick();
    chk("t4_lat3_valid", 32'(out_valid), 32'd1);
    chk("t4_lat3_data", 32'(out_data), 32'(clampf(8'h88)));
    chk("t4_cnt_zero", 32'(sample_cnt), 32'd0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/log_compress.md
LOG_COMPRESS -- requirements
Module: log_compress

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of unsigned input magnitude sample.
REQ-002 SHALL have parameter FRAC_BITS, default 4: fractional bits of log2 output.
REQ-003 SHALL have parameter FLOOR, default 8'h30: dynamic-range floor in Q4.4, used only with LOGC_CLAMP_EN.
REQ-004 SHALL derive OUT_WIDTH = clog2(DATA_WIDTH)+FRAC_BITS (default 8), not user-settable.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream sample (buffer data_out) valid.
REQ-008 in_ready  output  1  block accepts sample this cycle.
REQ-009 in_data  input  DATA_WIDTH  unsigned magnitude sample.
REQ-010 in_last  input  1  last sample of scan line.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_data  output  OUT_WIDTH  log2 value, unsigned Q(int).FRAC_BITS.
REQ-014 out_last  output  1  in_last delayed with its sample.
REQ-015 sample_cnt  output  16  count of samples delivered in current line.

Function
REQ-016 Transfer SHALL occur on a port when valid and ready are both high at a rising edge.
REQ-017 Pipeline SHALL be three register stages: S1 capture, S2 leading-one detect and normalise, S3 assemble/clamp.
REQ-018 Global advance SHALL be adv = !out_valid || out_ready; in_ready SHALL equal adv; all stages hold when adv low.
REQ-019 Latency SHALL be 3 cycles from input transfer to out_valid with out_ready held high; throughput one sample per cycle.
REQ-020 Integer part SHALL be index of most significant set bit of in_data (0..DATA_WIDTH-1).
REQ-021 Fraction SHALL be the FRAC_BITS bits immediately below the leading one, zero-padded when fewer exist; no rounding.
REQ-022 in_data = 0 SHALL produce out_data = 0.
REQ-023 out_last SHALL travel in lockstep with its sample; valid bubbles SHALL carry last = 0.
REQ-024 sample_cnt SHALL increment on each output transfer, reset to 0 on the cycle after a transfer with out_last = 1, and wrap modulo 2^16.
REQ-025 in_data/in_last SHALL be ignored when in_valid low; no sample is dropped or duplicated under any out_ready pattern.

Reset
REQ-026 reset SHALL clear all stage valid bits, out_valid = 0, out_data = 0, out_last = 0, sample_cnt = 0; in_ready = 1 the cycle after reset deasserts.
REQ-027 reset asserted mid-stream SHALL discard all in-flight samples; no output appears for them.

Configuration
REQ-028 Macro LOGC_CLAMP_EN defined: out_data SHALL be max(log2 - FLOOR, 0), saturating at 0.
REQ-029 LOGC_CLAMP_EN undefined: out_data SHALL be raw log2 value; FLOOR unused; latency unchanged.

Structure
REQ-030 Shared package logc_pkg SHALL hold DATA_WIDTH/FRAC_BITS defaults, OUT_WIDTH derivation function and the Q4.4 sample typedef.
REQ-031 Leading-one detector SHALL be a separate sub-module lod returning index and zero flag, purely combinational, instantiated in S2.

Verification
REQ-032 out_ready=1, inputs 0x0100,0x0180,0x0001,0x0000,0xFFFF back-to-back -> outputs 0x80,0x88,0x00,0x00,0xFF on cycles 3..7, clamp off.
REQ-033 LOGC_CLAMP_EN, FLOOR=0x30, inputs 0x0100,0x0004 -> 0x50,0x00.
REQ-034 Streaming 16 samples with out_ready toggling 1,0,0,1... -> all 16 outputs in order, in_ready low exactly while out_valid && !out_ready.
REQ-035 Line of 5 samples, last on 5th -> out_last high only with 5th output, sample_cnt 1..5 then 0.
REQ-036 reset pulsed one cycle with 3 samples in flight -> out_valid stays 0, sample_cnt 0, next input emerges after 3 cycles.
